// File: rtl/fifo_gen.sv
// Parametrised single-clock show-ahead FIFO with occupancy, thresholds,
// flush, sticky error flags and optional rising-edge request detection.
module fifo_gen #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int AF_LEVEL  = DEPTH - 4,
    parameter int AE_LEVEL  = 4,
    parameter int EDGE_TRIG = 0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_level,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic [AW:0]      level;
    logic             push_r;
    logic             pop_r;
    logic             overflow;
    logic             underflow;

    logic push_ev;
    logic pop_ev;
    logic push_acc;
    logic pop_acc;
    logic push_err;
    logic pop_err;

    // In edge mode a strobe held over several cycles is a single request.
    assign push_ev = (EDGE_TRIG != 0) ? (i_push & ~push_r) : i_push;
    assign pop_ev  = (EDGE_TRIG != 0) ? (i_pop & ~pop_r)   : i_pop;

    assign o_empty = (level == '0);
    assign o_full  = (level == FULL_LVL);

    assign pop_acc  = ~i_flush & pop_ev & ~o_empty;
    assign push_acc = ~i_flush & push_ev & (~o_full | pop_acc);
    assign push_err = ~i_flush & push_ev & ~push_acc;
    assign pop_err  = ~i_flush & pop_ev & ~pop_acc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_idx <= '0;
            wr_idx <= '0;
            level  <= '0;
            push_r <= 1'b0;
            pop_r  <= 1'b0;
        end else begin
            push_r <= i_push;
            pop_r  <= i_pop;
            if (i_flush) begin
                rd_idx <= '0;
                wr_idx <= '0;
                level  <= '0;
            end else begin
                if (push_acc) wr_idx <= wr_idx + AW'(1);
                if (pop_acc)  rd_idx <= rd_idx + AW'(1);
                case ({push_acc, pop_acc})
                    2'b10:   level <= level + (AW+1)'(1);
                    2'b01:   level <= level - (AW+1)'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    // Storage is deliberately left unreset; a full push+pop writes the slot being vacated.
    always_ff @(posedge i_clk) begin
        if (push_acc) mem[wr_idx] <= i_dat;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_err)       overflow <= 1'b1;
            else if (i_clr_err) overflow <= 1'b0;
            if (pop_err)        underflow <= 1'b1;
            else if (i_clr_err) underflow <= 1'b0;
        end
    end

    assign o_dat          = mem[rd_idx];
    assign o_level        = level;
    assign o_almost_full  = (level >= AF_LVL);
    assign o_almost_empty = (level <= AE_LVL);
    assign o_overflow     = overflow;
    assign o_underflow    = underflow;

endmodule

// File: tb/tb_fifo_gen.sv
// Drives three fifo_gen configurations from one stimulus stream and checks
// them against queue-based reference models.
module tb_fifo_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dat = '0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       flush = 1'b0;
    logic       clr = 1'b0;

    logic [7:0] dat_a, dat_b, dat_c;
    logic       emp_a, emp_b, emp_c;
    logic       ful_a, ful_b, ful_c;
    logic [2:0] lvl_a, lvl_c;
    logic [4:0] lvl_b;
    logic       af_a, af_b, af_c;
    logic       ae_a, ae_b, ae_c;
    logic       ov_a, ov_b, ov_c;
    logic       un_a, un_b, un_c;

    int checks = 0;
    int failures = 0;

    int depth_p [3] = '{4, 16, 4};
    int af_p    [3] = '{3, 12, 3};
    int ae_p    [3] = '{1, 4, 1};
    int edge_p  [3] = '{0, 0, 1};

    logic [7:0] q [3][$];
    logic       m_ov [3];
    logic       m_un [3];
    logic       m_pr [3];
    logic       m_ppr[3];

    always #5 clk = ~clk;

    fifo_gen #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .EDGE_TRIG(0)) u_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_dat(dat), .i_push(push), .i_pop(pop),
        .i_flush(flush), .i_clr_err(clr), .o_dat(dat_a), .o_empty(emp_a), .o_full(ful_a),
        .o_level(lvl_a), .o_almost_full(af_a), .o_almost_empty(ae_a),
        .o_overflow(ov_a), .o_underflow(un_a));

    fifo_gen #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .EDGE_TRIG(0)) u_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_dat(dat), .i_push(push), .i_pop(pop),
        .i_flush(flush), .i_clr_err(clr), .o_dat(dat_b), .o_empty(emp_b), .o_full(ful_b),
        .o_level(lvl_b), .o_almost_full(af_b), .o_almost_empty(ae_b),
        .o_overflow(ov_b), .o_underflow(un_b));

    fifo_gen #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .EDGE_TRIG(1)) u_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_dat(dat), .i_push(push), .i_pop(pop),
        .i_flush(flush), .i_clr_err(clr), .o_dat(dat_c), .o_empty(emp_c), .o_full(ful_c),
        .o_level(lvl_c), .o_almost_full(af_c), .o_almost_empty(ae_c),
        .o_overflow(ov_c), .o_underflow(un_c));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            m_ov[k]  = 1'b0;
            m_un[k]  = 1'b0;
            m_pr[k]  = 1'b0;
            m_ppr[k] = 1'b0;
        end
    endtask

    // One clock edge of each reference FIFO, using the inputs currently applied.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit pe, pv, pop_ok, push_ok;
            pe = (edge_p[k] != 0) ? (push && !m_pr[k]) : push;
            pv = (edge_p[k] != 0) ? (pop && !m_ppr[k]) : pop;
            if (clr) begin
                m_ov[k] = 1'b0;
                m_un[k] = 1'b0;
            end
            if (flush) begin
                q[k].delete();
            end else begin
                pop_ok  = pv && (q[k].size() > 0);
                push_ok = pe && ((q[k].size() < depth_p[k]) || pop_ok);
                if (pop_ok)  void'(q[k].pop_front());
                if (push_ok) q[k].push_back(dat);
                if (pe && !push_ok) m_ov[k] = 1'b1;
                if (pv && !pop_ok)  m_un[k] = 1'b1;
            end
            m_pr[k]  = push;
            m_ppr[k] = pop;
        end
    endtask

    task automatic check_inst(int k, logic [4:0] lvl, logic emp, logic ful, logic af,
                              logic ae, logic ov, logic un, logic [7:0] d);
        string t;
        int n;
        t = $sformatf("i%0d", k);
        n = q[k].size();
        chk({t, ".level"}, 32'(lvl), n);
        chk({t, ".empty"}, 32'(emp), 32'(n == 0));
        chk({t, ".full"},  32'(ful), 32'(n == depth_p[k]));
        chk({t, ".afull"}, 32'(af),  32'(n >= af_p[k]));
        chk({t, ".aempty"}, 32'(ae), 32'(n <= ae_p[k]));
        chk({t, ".ovf"},   32'(ov),  32'(m_ov[k]));
        chk({t, ".unf"},   32'(un),  32'(m_un[k]));
        if (n > 0) chk({t, ".head"}, 32'(d), 32'(q[k][0]));
    endtask

    task automatic check_all();
        check_inst(0, {2'b0, lvl_a}, emp_a, ful_a, af_a, ae_a, ov_a, un_a, dat_a);
        check_inst(1, lvl_b,         emp_b, ful_b, af_b, ae_b, ov_b, un_b, dat_b);
        check_inst(2, {2'b0, lvl_c}, emp_c, ful_c, af_c, ae_c, ov_c, un_c, dat_c);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr = 1'b0;
    endtask

    logic [7:0] fill_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] cnt = 8'h00;

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        #1;
        check_all();
        chk("a.rst_level", 32'(lvl_a), 0);
        chk("a.rst_empty", 32'(emp_a), 1);
        chk("a.rst_aempty", 32'(ae_a), 1);

        // Fill, overflow attempt, drain in order.
        push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat = fill_v[i];
            step();
            chk("a.fill_level", 32'(lvl_a), i + 1);
        end
        idle(); step();
        chk("a.full", 32'(ful_a), 1);
        push = 1'b1; dat = 8'h55; step(); idle();
        chk("a.ovf_set", 32'(ov_a), 1);
        chk("a.ovf_level", 32'(lvl_a), 4);
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("a.drain_head", 32'(dat_a), 32'(fill_v[i]));
            step();
        end
        idle(); step();
        chk("a.drained", 32'(emp_a), 1);
        clr = 1'b1; step(); idle();
        chk("a.ovf_clr", 32'(ov_a), 0);

        // Full with simultaneous push and pop.
        push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat = fill_v[i];
            step();
        end
        idle(); step();
        push = 1'b1; pop = 1'b1; dat = 8'hAA; step(); idle();
        chk("a.fullpp_level", 32'(lvl_a), 4);
        chk("a.fullpp_head", 32'(dat_a), 8'h22);
        pop = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("a.fullpp_last", 32'(dat_a), 8'hAA);
        step(); idle(); step();

        // Empty with simultaneous push and pop: no fall-through.
        push = 1'b1; pop = 1'b1; dat = 8'h5A; step(); idle();
        chk("a.emptypp_level", 32'(lvl_a), 1);
        chk("a.emptypp_head", 32'(dat_a), 8'h5A);
        chk("a.emptypp_unf", 32'(un_a), 1);

        // Flush beats a coincident push; sticky flags survive it.
        push = 1'b1;
        dat = 8'h01; step();
        dat = 8'h02; step();
        chk("a.preflush_level", 32'(lvl_a), 3);
        flush = 1'b1; dat = 8'h77; step(); idle();
        chk("a.flush_level", 32'(lvl_a), 0);
        chk("a.flush_unf", 32'(un_a), 1);
        chk("a.flush_ovf", 32'(ov_a), 0);

        // Asynchronous reset mid-cycle.
        push = 1'b1;
        dat = 8'h11; step();
        dat = 8'h22; step();
        idle();
        chk("a.prerst_level", 32'(lvl_a), 2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("a.arst_empty", 32'(emp_a), 1);
        chk("a.arst_unf", 32'(un_a), 0);
        chk("b.arst_empty", 32'(emp_b), 1);
        chk("c.arst_empty", 32'(emp_c), 1);
        #2 rst_n = 1'b1;

        // Held strobes: edge-mode instance sees one request each.
        push = 1'b1; dat = 8'h3C;
        for (int i = 0; i < 5; i++) step();
        push = 1'b0;
        chk("c.hold_push_level", 32'(lvl_c), 1);
        chk("c.hold_push_head", 32'(dat_c), 8'h3C);
        pop = 1'b1;
        for (int i = 0; i < 3; i++) step();
        pop = 1'b0;
        chk("c.hold_pop_level", 32'(lvl_c), 0);
        chk("c.hold_pop_unf", 32'(un_c), 0);
        clr = 1'b1; step(); idle();

        // Randomised traffic with an incrementing data stream.
        for (int i = 0; i < 900; i++) begin
            int pp;
            pp = (i < 300) ? 70 : ((i < 600) ? 30 : 50);
            push  = ($urandom_range(99) < pp);
            pop   = ($urandom_range(99) < (100 - pp));
            flush = ($urandom_range(199) == 0);
            clr   = !flush && ($urandom_range(49) == 0);
            dat   = cnt;
            if (push) cnt = cnt + 8'd1;
            step();
        end
        idle(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_gen.md
Name: fifo_gen

Overview:
- Parametrised single-clock byte/word FIFO; next generation of the team's 4-byte UART FIFO.
- Generalises data width and depth.
- Adds occupancy count, almost-full/almost-empty thresholds, simultaneous push+pop, synchronous flush, and sticky overflow/underflow error flags.
- Selectable strobe mode: level-per-cycle, or rising-edge (for slow bus strobes held over several cycles).
- Sits between the UART byte engines and the Wishbone side of the bridge.

Parameters:
- WIDTH, 8: data word width in bits, >=1.
- DEPTH, 16: number of entries; power of two, >=2.
- AW, $clog2(DEPTH): index width; derived, not to be overridden.
- AF_LEVEL, DEPTH-4: o_almost_full asserts when level >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 4: o_almost_empty asserts when level <= AE_LEVEL; range 0..DEPTH-1.
- EDGE_TRIG, 0: 0 = i_push/i_pop sampled every cycle as a request; 1 = only a 0->1 transition is a request.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_dat  in  WIDTH  write data.
- i_push  in  1  write request.
- i_pop  in  1  read request.
- i_flush  in  1  synchronous discard of all contents.
- i_clr_err  in  1  synchronous clear of sticky error flags.
- o_dat  out  WIDTH  head-of-queue data (show-ahead).
- o_empty  out  1  level == 0.
- o_full  out  1  level == DEPTH.
- o_level  out  AW+1  current occupancy, 0..DEPTH.
- o_almost_full  out  1  level >= AF_LEVEL.
- o_almost_empty  out  1  level <= AE_LEVEL.
- o_overflow  out  1  sticky: push dropped.
- o_underflow  out  1  sticky: pop on empty.

Behaviour:
- Reset (async assert, sync-safe release): rd_idx=0, wr_idx=0, level=0, edge-detect registers=0.
  - Outputs after reset: o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_overflow=0, o_underflow=0.
  - Storage array is not reset. o_dat is don't-care while empty.
  - Reset mid-operation discards contents immediately, without waiting for a clock edge.
- Request events:
  - EDGE_TRIG=0: push_ev=i_push, pop_ev=i_pop.
  - EDGE_TRIG=1: push_ev=i_push & ~push_r, pop_ev=i_pop & ~pop_r. push_r/pop_r are registered copies, reset to 0, so a strobe already high at reset release counts as one event.
- Acceptance, evaluated each rising edge:
  - pop_acc = pop_ev & ~o_empty.
  - push_acc = push_ev & (~o_full | pop_acc).
- Effect of accepted requests:
  - push_acc: mem[wr_idx] <= i_dat; wr_idx += 1 (mod DEPTH).
  - pop_acc: rd_idx += 1 (mod DEPTH).
  - level += push_acc - pop_acc.
- o_dat = mem[rd_idx], combinational. Latency: data pushed at edge N is visible on o_dat after edge N if the FIFO was empty. The consumer samples o_dat in the same cycle it asserts pop.
- Full + push + pop: both accepted; level stays DEPTH. The write lands in the slot being vacated; the old head is consumed at that edge.
- Empty + push + pop: push accepted, pop rejected (no fall-through); level becomes 1; o_underflow sets.
- Error flags:
  - push_ev & ~push_acc sets o_overflow; the data is dropped and state is unchanged.
  - pop_ev & ~pop_acc sets o_underflow.
  - Flags hold until i_clr_err or reset.
  - If i_clr_err coincides with a new error event, the set wins.
- i_flush has priority over push/pop in the same cycle:
  - rd_idx=wr_idx=level=0; requests that cycle are ignored and raise no errors.
  - Edge-detect registers still update.
  - Error flags are unaffected by flush.
- Indices wrap naturally at DEPTH (AW bits). Full/empty come from the level register, never from index comparison.
- All status outputs are decoded from registered level and change only on clock edges or async reset.

Test Plan:
- Reset/fill/drain (DEPTH=4, EDGE_TRIG=0): reset -> o_empty=1, o_level=0, o_almost_empty=1. Push 0x11,0x22,0x33,0x44 on consecutive cycles -> o_level 1,2,3,4, o_full=1. Pop 4 cycles -> o_dat 0x11,0x22,0x33,0x44 in order, then o_empty=1.
- Overflow (DEPTH=4): when full, push 0x55 alone -> o_overflow=1, o_level=4, contents unchanged. Next pops return 0x11..0x44. i_clr_err -> o_overflow=0.
- Simultaneous ops (DEPTH=4): full + push 0xAA + pop -> level stays 4, 0x11 consumed, 0xAA read 4th. Empty + push 0x5A + pop -> level=1, o_dat=0x5A, o_underflow=1.
- Wrap-around and thresholds (DEPTH=16, AF=12, AE=4): 40 interleaved push/pop of an incrementing counter -> data stream is monotonic with no loss. o_almost_full toggles exactly at the 11->12 level crossing; o_almost_empty toggles exactly at 5->4.
- Edge mode (EDGE_TRIG=1): hold i_push high 5 cycles with i_dat=0x3C -> exactly one entry, level=1. Hold i_pop high 3 cycles -> one pop, level=0, no underflow.
- Flush/async reset: with level=3, assert i_flush together with a push -> level=0, no entry written, flags unchanged. With level=2, drop i_reset_n mid-cycle -> o_empty=1 before the next edge.
